uart_irq_ctrl_gen: RTL and testbench
====================================

// Module: uart_irq_ctrl_gen
// PURPOSE
//  Parametrised UART interrupt controller. Replaces the fixed 4-source controller.
//  Collects NUM_SRC interrupt requests from the UART datapath: RX error, RX timeout, RX level, TX level, modem, DMA.
//  Each source is individually enabled and selectable as level- or edge-triggered.
//  Exposes enable/status/mode/raw/ID registers on the DSP bus and drives a single nIRQ with a programmable re-arm gap.
// PARAMETERS
//  NUM_SRC   8   number of interrupt sources, 1..16
//  GAP_CYC   4   nIRQ high time after acknowledge, in DSP_CLK cycles; 0 is treated as 1
//  ID_W      4   width of the encoded source ID; must satisfy 2**ID_W >= NUM_SRC
// PORTS
//  DSP_CLK    in   1        single clock
//  RESET      in   1        synchronous reset, active-high
//  DSP_CEn    in   1        chip enable, active-low
//  DSP_WEn    in   1        0 = write, 1 = read
//  DSP_ADDR   in   4        register address [4:1]
//  DSP_WDATA  in   32       write data
//  DSP_RDATA  out  32       registered read data; bits [31:16] always 0
//  INT_SRC    in   NUM_SRC  raw source requests, synchronous to DSP_CLK
//  nIRQ       out  1        interrupt request, active-low
// BEHAVIOUR
//  Reset (RESET=1 at a clock edge) clears all state: IER=0, IMODE=0, PEND=0, src_d=0,
//   RDATA=0, FSM=ST_IDLE, gap counter=0, nIRQ=1. Reset mid-operation aborts any gap and
//   drops pending events.
//  Strobes: wr = !CEn & !WEn; rd = !CEn & WEn.
//  Register map:
//   0x5 IER    RW  [NUM_SRC-1:0] enables
//   0x6 ISR    R = PEND & IER; W = write-1-to-clear PEND
//   0x7 IMODE  RW  1 = edge (rising), 0 = level
//   0x8 IRAW   RO  PEND unmasked; writes ignored
//   0x9 IID    RO  [15] valid, [ID_W-1:0] lowest-index set bit of ISR; 0 when none
//  Unused register bits read 0. Writes to undefined addresses are ignored.
//  Read latency: RDATA is updated on the clock edge where rd is sampled and holds
//   until the next read of a defined address. A read of an undefined address leaves
//   RDATA unchanged. Read data reflects register values before that edge's update.
//  Event detection: src_d <= INT_SRC every cycle.
//   Level event: INT_SRC[i] = 1. Edge event: INT_SRC[i] & !src_d[i].
//   Events are captured into PEND regardless of IER; IER masks only ISR, IID and nIRQ.
//  Simultaneous event and W1C on the same bit: the set wins and the bit stays 1.
//   A level source still high after a clear therefore re-pends immediately.
//  Changing IMODE takes effect next cycle and does not clear PEND.
//  IRQ FSM (2-bit state):
//   ST_IDLE: nIRQ=1; if |ISR -> ST_IRQ.
//   ST_IRQ:  nIRQ=0; a write to 0x6 (any data), or ISR == 0 (e.g. IER cleared) ->
//            ST_GAP, counter <= max(GAP_CYC,1) - 1.
//   ST_GAP:  nIRQ=1; counter decrements; at 0 -> ST_IDLE.
//            Sources may pend during the gap.
//  nIRQ is registered: it falls one cycle after ISR becomes nonzero in ST_IDLE.
//   It rises the cycle after the acknowledge write. Minimum high time is GAP_CYC
//   cycles before it can fall again.
//  IID priority: index 0 is highest; computed combinationally and sampled only on read.
// STRUCTURE
//  Shared package uart_pkg: register address constants (ADDR_IER..ADDR_IID), FSM state
//   encodings ST_IDLE/ST_IRQ/ST_GAP, the function clog2.
//  One sub-module, uart_irq_src: per-bit edge detect + pending flop with set-over-clear.
//   It is instantiated NUM_SRC times via generate.
//  The top level holds the register file, the read mux, the priority encoder and the FSM.
// TESTING
//  1 Reset:
//    hold RESET 2 cycles mid-IRQ -> nIRQ=1, IER/ISR/IRAW read 0, RDATA=0.
//  2 Level source:
//    IER=0x04, IMODE=0, INT_SRC[2]=1 -> nIRQ=0 two cycles later; ISR reads 0x0004;
//    IID reads 0x8002.
//    Write 0x6=0x04 with src still high -> nIRQ=1 for GAP_CYC=4 cycles, then 0 again.
//  3 Edge source:
//    IMODE=0x01, IER=0x01, INT_SRC[0] held high 10 cycles -> single pend.
//    W1C 0x01 -> ISR=0 and nIRQ stays 1 after the gap.
//  4 Mask:
//    IER=0, pulse INT_SRC[5] -> nIRQ=1, ISR=0, IRAW=0x0020.
//    Then IER=0x20 -> nIRQ falls next cycle.
//  5 Priority and set-wins:
//    pend sources 1 and 6 -> IID=0x8001.
//    Edge on src 1 in the same cycle as W1C of bit 1 -> IRAW bit1 stays 1.
//  6 Unmask-drop:
//    in ST_IRQ write IER=0 -> nIRQ rises next cycle, re-asserts only after the gap
//    and after a new enable.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART interrupt controller: register map, IRQ FSM states
// and the elaboration-time clog2 helper.
package uart_pkg;

   localparam logic [3:0] ADDR_IER   = 4'h5;
   localparam logic [3:0] ADDR_ISR   = 4'h6;
   localparam logic [3:0] ADDR_IMODE = 4'h7;
   localparam logic [3:0] ADDR_IRAW  = 4'h8;
   localparam logic [3:0] ADDR_IID   = 4'h9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IRQ  = 2'd1,
      ST_GAP  = 2'd2
   } irqState_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = 1; v < n; v = v << 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/uart_irq_src.sv
// One interrupt source: input delay for edge detection plus a pending flop
// in which a new event always beats a simultaneous write-1-to-clear.
module uart_irq_src (
   input  logic DSP_CLK,
   input  logic RESET,
   input  logic srcIn,
   input  logic edgeMode,
   input  logic clrReq,
   output logic pend
);

   logic srcD;
   logic srcEvent;

   assign srcEvent = edgeMode ? (srcIn & ~srcD) : srcIn;

   always_ff @(posedge DSP_CLK) begin
      if (RESET) begin
         srcD <= 1'b0;
         pend <= 1'b0;
      end else begin
         srcD <= srcIn;
         if (srcEvent)
            pend <= 1'b1;
         else if (clrReq)
            pend <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_irq_ctrl_gen.sv
// Parametrised UART interrupt controller: register file, read mux, priority encoder
// and the nIRQ assert/acknowledge/re-arm FSM.
module uart_irq_ctrl_gen
   import uart_pkg::*;
#(
   parameter int unsigned NUM_SRC = 8,
   parameter int unsigned GAP_CYC = 4,
   parameter int unsigned ID_W    = 4
) (
   input  logic               DSP_CLK,
   input  logic               RESET,
   input  logic               DSP_CEn,
   input  logic               DSP_WEn,
   input  logic [3:0]         DSP_ADDR,
   input  logic [31:0]        DSP_WDATA,
   output logic [31:0]        DSP_RDATA,
   input  logic [NUM_SRC-1:0] INT_SRC,
   output logic               nIRQ
);

   localparam int unsigned GAP_EFF = (GAP_CYC == 0) ? 1 : GAP_CYC;
   localparam int unsigned CNT_W   = (clog2(GAP_EFF) < 1) ? 1 : clog2(GAP_EFF);

   logic               wr;
   logic               rd;
   logic               ackWr;
   logic [NUM_SRC-1:0] ier;
   logic [NUM_SRC-1:0] imode;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] isr;
   logic [NUM_SRC-1:0] clrMask;
   logic [ID_W-1:0]    iidVal;
   logic               iidValid;
   logic [31:0]        rdNext;
   logic               rdHit;
   irqState_t          state;
   irqState_t          nextState;
   logic [CNT_W-1:0]   gapCnt;
   logic [CNT_W-1:0]   gapNext;
   logic               nIrqNext;
   logic               unusedWdata;

   assign wr          = ~DSP_CEn & ~DSP_WEn;
   assign rd          = ~DSP_CEn &  DSP_WEn;
   assign ackWr       = wr && (DSP_ADDR == ADDR_ISR);
   assign clrMask     = ackWr ? DSP_WDATA[NUM_SRC-1:0] : '0;
   assign isr         = pend & ier;
   assign unusedWdata = ^DSP_WDATA[31:NUM_SRC];

   for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
      uart_irq_src uSrc (
         .DSP_CLK  (DSP_CLK),
         .RESET    (RESET),
         .srcIn    (INT_SRC[g]),
         .edgeMode (imode[g]),
         .clrReq   (clrMask[g]),
         .pend     (pend[g])
      );
   end

   // Lowest index wins; the first hit freezes the result.
   always_comb begin
      iidVal   = '0;
      iidValid = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (isr[i] && !iidValid) begin
            iidValid = 1'b1;
            iidVal   = ID_W'(i);
         end
      end
   end

   always_comb begin
      rdNext = '0;
      rdHit  = 1'b1;
      case (DSP_ADDR)
         ADDR_IER:   rdNext[NUM_SRC-1:0] = ier;
         ADDR_ISR:   rdNext[NUM_SRC-1:0] = isr;
         ADDR_IMODE: rdNext[NUM_SRC-1:0] = imode;
         ADDR_IRAW:  rdNext[NUM_SRC-1:0] = pend;
         ADDR_IID: begin
            rdNext[15]       = iidValid;
            rdNext[ID_W-1:0] = iidVal;
         end
         default:    rdHit = 1'b0;
      endcase
   end

   always_ff @(posedge DSP_CLK) begin
      if (RESET) begin
         ier       <= '0;
         imode     <= '0;
         DSP_RDATA <= '0;
      end else begin
         if (wr && (DSP_ADDR == ADDR_IER))   ier   <= DSP_WDATA[NUM_SRC-1:0];
         if (wr && (DSP_ADDR == ADDR_IMODE)) imode <= DSP_WDATA[NUM_SRC-1:0];
         if (rd && rdHit)                    DSP_RDATA <= rdNext;
      end
   end

   always_ff @(posedge DSP_CLK) begin
      if (RESET) begin
         state  <= ST_IDLE;
         gapCnt <= '0;
         nIRQ   <= 1'b1;
      end else begin
         state  <= nextState;
         gapCnt <= gapNext;
         nIRQ   <= nIrqNext;
      end
   end

   always_comb begin
      nextState = state;
      gapNext   = gapCnt;
      case (state)
         ST_IDLE: if (|isr) nextState = ST_IRQ;
         ST_IRQ: begin
            if (ackWr || ~|isr) begin
               nextState = ST_GAP;
               gapNext   = CNT_W'(GAP_EFF - 1);
            end
         end
         ST_GAP: begin
            if (gapCnt == '0) nextState = ST_IDLE;
            else              gapNext   = gapCnt - CNT_W'(1);
         end
         default: nextState = ST_IDLE;
      endcase
   end

   // nIRQ is driven from the upcoming state so the output itself is a flop.
   always_comb begin
      nIrqNext = (nextState != ST_IRQ);
   end

endmodule

// File: tb/tb_uart_irq_ctrl_gen.sv
// Self-checking bench for uart_irq_ctrl_gen: directed scenarios with fixed expectations
// plus randomized traffic checked against a cycle-level behavioural model.
module tb_uart_irq_ctrl_gen;

   localparam int NS  = 8;
   localparam int GAP = 4;

   logic        DSP_CLK;
   logic        RESET;
   logic        DSP_CEn;
   logic        DSP_WEn;
   logic [3:0]  DSP_ADDR;
   logic [31:0] DSP_WDATA;
   logic [31:0] DSP_RDATA;
   logic [7:0]  INT_SRC;
   logic        nIRQ;

   int passCnt  = 0;
   int totalCnt = 0;

   uart_irq_ctrl_gen #(.NUM_SRC(NS), .GAP_CYC(GAP), .ID_W(4)) dut (
      .DSP_CLK   (DSP_CLK),
      .RESET     (RESET),
      .DSP_CEn   (DSP_CEn),
      .DSP_WEn   (DSP_WEn),
      .DSP_ADDR  (DSP_ADDR),
      .DSP_WDATA (DSP_WDATA),
      .DSP_RDATA (DSP_RDATA),
      .INT_SRC   (INT_SRC),
      .nIRQ      (nIRQ)
   );

   initial DSP_CLK = 1'b0;
   always #5 DSP_CLK = ~DSP_CLK;

   // Behavioural model: registers, pending set and an nIRQ line with a hold-off countdown.
   logic [7:0]  mIer, mMode, mPend, mPrev, mIsrOld, mEv, mClr;
   logic [31:0] mRdata;
   logic        mLow;
   int          mHold;
   int          mIdx;
   logic        mWr, mRd;

   always @(posedge DSP_CLK) begin
      mIsrOld = mPend & mIer;
      if (RESET) begin
         mIer = '0; mMode = '0; mPend = '0; mPrev = '0;
         mRdata = '0; mLow = 1'b0; mHold = 0;
      end else begin
         mWr = !DSP_CEn && !DSP_WEn;
         mRd = !DSP_CEn &&  DSP_WEn;
         if (mRd) begin
            case (DSP_ADDR)
               4'h5: mRdata = {24'h0, mIer};
               4'h6: mRdata = {24'h0, mIsrOld};
               4'h7: mRdata = {24'h0, mMode};
               4'h8: mRdata = {24'h0, mPend};
               4'h9: begin
                  mIdx = -1;
                  for (int i = NS - 1; i >= 0; i--) if (mIsrOld[i]) mIdx = i;
                  mRdata = (mIdx < 0) ? 32'h0 : (32'h8000 + 32'(mIdx));
               end
               default: ;
            endcase
         end
         mEv   = (mMode & INT_SRC & ~mPrev) | (~mMode & INT_SRC);
         mClr  = (mWr && DSP_ADDR == 4'h6) ? DSP_WDATA[7:0] : 8'h0;
         mPend = (mPend & ~mClr) | mEv;
         if (mWr && DSP_ADDR == 4'h5) mIer  = DSP_WDATA[7:0];
         if (mWr && DSP_ADDR == 4'h7) mMode = DSP_WDATA[7:0];
         if (mLow) begin
            if ((mWr && DSP_ADDR == 4'h6) || mIsrOld == 8'h0) begin
               mLow  = 1'b0;
               mHold = GAP;
            end
         end else if (mHold > 0) mHold--;
         else if (mIsrOld != 8'h0) mLow = 1'b1;
         mPrev = INT_SRC;
      end
   end

   task automatic tick();
      @(posedge DSP_CLK);
      @(negedge DSP_CLK);
   endtask

   task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
      DSP_CEn = 1'b0; DSP_WEn = 1'b0; DSP_ADDR = a; DSP_WDATA = d;
      tick();
      DSP_CEn = 1'b1; DSP_WEn = 1'b1;
   endtask

   task automatic busRead(input logic [3:0] a, output logic [31:0] d);
      DSP_CEn = 1'b0; DSP_WEn = 1'b1; DSP_ADDR = a;
      tick();
      d = DSP_RDATA;
      DSP_CEn = 1'b1;
   endtask

   task automatic cleanup();
      INT_SRC = '0;
      busWrite(4'h5, 32'h0);
      busWrite(4'h6, 32'hFF);
      busWrite(4'h7, 32'h0);
      repeat (10) tick();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      busWrite(4'h5, 32'h04);
      INT_SRC = 8'h04;
      tick(); tick();
      totalCnt++; if (nIRQ !== 1'b0) $display("FAIL rst_pre_irq: got %b want 0", nIRQ); else passCnt++;
      busRead(4'h5, d);
      totalCnt++; if (d !== 32'h4) $display("FAIL rst_pre_ier: got %h want 00000004", d); else passCnt++;
      INT_SRC = '0;
      RESET = 1'b1;
      tick(); tick();
      RESET = 1'b0;
      totalCnt++; if (nIRQ !== 1'b1) $display("FAIL rst_nirq: got %b want 1", nIRQ); else passCnt++;
      totalCnt++; if (DSP_RDATA !== 32'h0) $display("FAIL rst_rdata: got %h want 0", DSP_RDATA); else passCnt++;
      busRead(4'h5, d);
      totalCnt++; if (d !== 32'h0) $display("FAIL rst_ier: got %h want 0", d); else passCnt++;
      busRead(4'h6, d);
      totalCnt++; if (d !== 32'h0) $display("FAIL rst_isr: got %h want 0", d); else passCnt++;
      busRead(4'h8, d);
      totalCnt++; if (d !== 32'h0) $display("FAIL rst_iraw: got %h want 0", d); else passCnt++;
   endtask

   task automatic test_level();
      logic [31:0] d;
      busWrite(4'h5, 32'h04);
      INT_SRC = 8'h04;
      tick();
      totalCnt++; if (nIRQ !== 1'b1) $display("FAIL lvl_lat1: got %b want 1", nIRQ); else passCnt++;
      tick();
      totalCnt++; if (nIRQ !== 1'b0) $display("FAIL lvl_fall: got %b want 0", nIRQ); else passCnt++;
      busRead(4'h6, d);
      totalCnt++; if (d !== 32'h4) $display("FAIL lvl_isr: got %h want 00000004", d); else passCnt++;
      busRead(4'h9, d);
      totalCnt++; if (d !== 32'h8002) $display("FAIL lvl_iid: got %h want 00008002", d); else passCnt++;
      busWrite(4'h6, 32'h04);
      totalCnt++; if (nIRQ !== 1'b1) $display("FAIL lvl_ack_rise: got %b want 1", nIRQ); else passCnt++;
      for (int i = 0; i < GAP; i++) begin
         tick();
         totalCnt++; if (nIRQ !== 1'b1) $display("FAIL lvl_gap%0d: got %b want 1", i, nIRQ); else passCnt++;
      end
      tick();
      totalCnt++; if (nIRQ !== 1'b0) $display("FAIL lvl_rearm: got %b want 0", nIRQ); else passCnt++;
      cleanup();
   endtask

   task automatic test_edge();
      logic [31:0] d;
      busWrite(4'h7, 32'h01);
      busWrite(4'h5, 32'h01);
      INT_SRC = 8'h01;
      repeat (10) tick();
      totalCnt++; if (nIRQ !== 1'b0) $display("FAIL edge_irq: got %b want 0", nIRQ); else passCnt++;
      busRead(4'h8, d);
      totalCnt++; if (d !== 32'h1) $display("FAIL edge_iraw: got %h want 00000001", d); else passCnt++;
      busWrite(4'h6, 32'h01);
      busRead(4'h6, d);
      totalCnt++; if (d !== 32'h0) $display("FAIL edge_isr_clr: got %h want 0", d); else passCnt++;
      for (int i = 0; i < 8; i++) begin
         tick();
         totalCnt++; if (nIRQ !== 1'b1) $display("FAIL edge_no_repend%0d: got %b want 1", i, nIRQ); else passCnt++;
      end
      cleanup();
   endtask

   task automatic test_mask();
      logic [31:0] d;
      busWrite(4'h5, 32'h0);
      INT_SRC = 8'h20;
      tick();
      INT_SRC = 8'h00;
      tick();
      totalCnt++; if (nIRQ !== 1'b1) $display("FAIL mask_nirq: got %b want 1", nIRQ); else passCnt++;
      busRead(4'h6, d);
      totalCnt++; if (d !== 32'h0) $display("FAIL mask_isr: got %h want 0", d); else passCnt++;
      busRead(4'h8, d);
      totalCnt++; if (d !== 32'h20) $display("FAIL mask_iraw: got %h want 00000020", d); else passCnt++;
      busWrite(4'h5, 32'h20);
      totalCnt++; if (nIRQ !== 1'b1) $display("FAIL mask_en_edge: got %b want 1", nIRQ); else passCnt++;
      tick();
      totalCnt++; if (nIRQ !== 1'b0) $display("FAIL mask_fall: got %b want 0", nIRQ); else passCnt++;
      cleanup();
   endtask

   task automatic test_priority();
      logic [31:0] d;
      busWrite(4'h7, 32'h02);
      busWrite(4'h5, 32'h42);
      INT_SRC = 8'h42;
      tick();
      INT_SRC = 8'h00;
      tick();
      busRead(4'h9, d);
      totalCnt++; if (d !== 32'h8001) $display("FAIL prio_iid: got %h want 00008001", d); else passCnt++;
      INT_SRC = 8'h02;
      DSP_CEn = 1'b0; DSP_WEn = 1'b0; DSP_ADDR = 4'h6; DSP_WDATA = 32'h02;
      tick();
      DSP_CEn = 1'b1; DSP_WEn = 1'b1; INT_SRC = 8'h00;
      busRead(4'h8, d);
      totalCnt++; if (d !== 32'h42) $display("FAIL prio_setwins: got %h want 00000042", d); else passCnt++;
      busRead(4'h9, d);
      totalCnt++; if (d !== 32'h8001) $display("FAIL prio_iid2: got %h want 00008001", d); else passCnt++;
      cleanup();
   endtask

   task automatic test_unmask_drop();
      busWrite(4'h5, 32'h08);
      INT_SRC = 8'h08;
      tick(); tick();
      totalCnt++; if (nIRQ !== 1'b0) $display("FAIL drop_irq: got %b want 0", nIRQ); else passCnt++;
      busWrite(4'h5, 32'h0);
      totalCnt++; if (nIRQ !== 1'b0) $display("FAIL drop_lag: got %b want 0", nIRQ); else passCnt++;
      tick();
      totalCnt++; if (nIRQ !== 1'b1) $display("FAIL drop_rise: got %b want 1", nIRQ); else passCnt++;
      for (int i = 0; i < 8; i++) begin
         tick();
         totalCnt++; if (nIRQ !== 1'b1) $display("FAIL drop_hold%0d: got %b want 1", i, nIRQ); else passCnt++;
      end
      busWrite(4'h5, 32'h08);
      totalCnt++; if (nIRQ !== 1'b1) $display("FAIL drop_en_edge: got %b want 1", nIRQ); else passCnt++;
      tick();
      totalCnt++; if (nIRQ !== 1'b0) $display("FAIL drop_reassert: got %b want 0", nIRQ); else passCnt++;
      cleanup();
   endtask

   task automatic test_random();
      int unsigned r;
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 199);
         DSP_CEn = 1'b1; DSP_WEn = 1'b1;
         RESET = (r == 0);
         if (r < 50) begin
            DSP_CEn   = 1'b0;
            DSP_WEn   = 1'($urandom_range(0, 1));
            DSP_ADDR  = 4'($urandom_range(4, 10));
            DSP_WDATA = $urandom;
         end
         if ($urandom_range(0, 3) == 0) INT_SRC = 8'($urandom);
         tick();
         totalCnt++; if (nIRQ !== !mLow) $display("FAIL rnd_nirq@%0d: got %b want %b", n, nIRQ, !mLow); else passCnt++;
         totalCnt++; if (DSP_RDATA !== mRdata) $display("FAIL rnd_rdata@%0d: got %h want %h", n, DSP_RDATA, mRdata); else passCnt++;
      end
      RESET = 1'b0; DSP_CEn = 1'b1; DSP_WEn = 1'b1;
   endtask

   initial begin
      RESET = 1'b1; DSP_CEn = 1'b1; DSP_WEn = 1'b1;
      DSP_ADDR = '0; DSP_WDATA = '0; INT_SRC = '0;
      tick(); tick();
      RESET = 1'b0;
      test_reset();
      test_level();
      test_edge();
      test_mask();
      test_priority();
      test_unmask_drop();
      test_random();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
